// File: rtl/conv_chin_accum_bias_relu.sv
// Input-channel accumulator for the 7x7 conv: sums CHANNEL_NUM_IN partial planes
// per output channel, adds a per-channel bias from a FIFO, then optional ReLU.
module conv_chin_accum_bias_relu #(
  parameter int DATA_WIDTH      = 32,
  parameter int IMAGE_SIZE      = 16,
  parameter int CHANNEL_NUM_IN  = 3,
  parameter int CHANNEL_NUM_OUT = 8,
  parameter int RELU_EN         = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  valid_bias_in,
  input  logic [DATA_WIDTH-1:0] bias_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  plane_done,
  output logic                  bias_err
);

  localparam int PW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int CW = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
  localparam int OW = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
  localparam int FW = $clog2(CHANNEL_NUM_OUT + 1);

  localparam logic [PW-1:0] PIX_LAST   = PW'(IMAGE_SIZE - 1);
  localparam logic [CW-1:0] CHIN_LAST  = CW'(CHANNEL_NUM_IN - 1);
  localparam logic [OW-1:0] CHOUT_LAST = OW'(CHANNEL_NUM_OUT - 1);
  localparam logic [OW-1:0] PTR_LAST   = OW'(CHANNEL_NUM_OUT - 1);
  localparam logic [FW-1:0] FIFO_DEPTH = FW'(CHANNEL_NUM_OUT);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Counters
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [CW-1:0] chin_cnt_q, chin_cnt_d;
  logic [OW-1:0] chout_cnt_q, chout_cnt_d;

  // Bias FIFO and the held per-channel bias
  logic [DATA_WIDTH-1:0] fifo_mem_q [CHANNEL_NUM_OUT];
  logic [OW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [DATA_WIDTH-1:0] cur_bias_q, cur_bias_d;

  // Partial-sum plane, asynchronous read
  logic [DATA_WIDTH-1:0] plane_mem_q [IMAGE_SIZE];

  // Outputs
  logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  plane_done_q, plane_done_d;
  logic                  bias_err_q, bias_err_d;

  // Datapath intermediates
  logic                  pix_last, chin_last, chout_last;
  logic                  first_beat;
  logic                  fifo_empty, fifo_full;
  logic                  pop, push;
  logic [DATA_WIDTH-1:0] pop_bias;
  logic [DATA_WIDTH-1:0] summand;
  logic [DATA_WIDTH:0]   wide_sum;
  logic [DATA_WIDTH-1:0] sum_sat;
  logic                  plane_we;

  always_comb begin
    pix_last   = (pix_cnt_q == PIX_LAST);
    chin_last  = (chin_cnt_q == CHIN_LAST);
    chout_last = (chout_cnt_q == CHOUT_LAST);
    first_beat = valid_in && (pix_cnt_q == '0) && (chin_cnt_q == '0);

    fifo_empty = (fifo_cnt_q == '0);
    fifo_full  = (fifo_cnt_q == FIFO_DEPTH);
    pop        = first_beat && !fifo_empty;
    // A full FIFO still accepts a push when the same cycle frees a slot
    push       = valid_bias_in && (!fifo_full || pop);
    pop_bias   = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
  end

  always_comb begin
    if (chin_cnt_q == '0) begin
      summand = (pix_cnt_q == '0) ? pop_bias : cur_bias_q;
    end else begin
      summand = plane_mem_q[pix_cnt_q];
    end

    wide_sum = {summand[DATA_WIDTH-1], summand} + {pxl_in[DATA_WIDTH-1], pxl_in};
    if (wide_sum[DATA_WIDTH] != wide_sum[DATA_WIDTH-1]) begin
      sum_sat = wide_sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_sat = wide_sum[DATA_WIDTH-1:0];
    end

    plane_we = valid_in && !chin_last;
  end

  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    chin_cnt_d  = chin_cnt_q;
    chout_cnt_d = chout_cnt_q;
    if (valid_in) begin
      if (pix_last) begin
        pix_cnt_d = '0;
        if (chin_last) begin
          chin_cnt_d  = '0;
          chout_cnt_d = chout_last ? '0 : chout_cnt_q + OW'(1);
        end else begin
          chin_cnt_d = chin_cnt_q + CW'(1);
        end
      end else begin
        pix_cnt_d = pix_cnt_q + PW'(1);
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    cur_bias_d = cur_bias_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + OW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + OW'(1);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (first_beat) begin
      cur_bias_d = pop_bias;
    end
  end

  always_comb begin
    valid_out_d  = valid_in && chin_last;
    plane_done_d = valid_in && chin_last && pix_last;
    pxl_out_d    = pxl_out_q;
    if (valid_out_d) begin
      pxl_out_d = ((RELU_EN != 0) && sum_sat[DATA_WIDTH-1]) ? '0 : sum_sat;
    end
    bias_err_d = bias_err_q
               || (first_beat && fifo_empty)
               || (valid_bias_in && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pix_cnt_q    <= '0;
      chin_cnt_q   <= '0;
      chout_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      cur_bias_q   <= '0;
      pxl_out_q    <= '0;
      valid_out_q  <= 1'b0;
      plane_done_q <= 1'b0;
      bias_err_q   <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      chin_cnt_q   <= chin_cnt_d;
      chout_cnt_q  <= chout_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      cur_bias_q   <= cur_bias_d;
      pxl_out_q    <= pxl_out_d;
      valid_out_q  <= valid_out_d;
      plane_done_q <= plane_done_d;
      bias_err_q   <= bias_err_d;
    end
  end

  // Storage arrays carry no reset; they are always written before being read
  always_ff @(posedge clk) begin
    if (reset && push) begin
      fifo_mem_q[wr_ptr_q] <= bias_in;
    end
    if (reset && plane_we) begin
      plane_mem_q[pix_cnt_q] <= sum_sat;
    end
  end

  assign pxl_out    = pxl_out_q;
  assign valid_out  = valid_out_q;
  assign plane_done = plane_done_q;
  assign bias_err   = bias_err_q;

endmodule

// File: doc/conv_chin_accum_bias_relu.md
Name: conv_chin_accum_bias_relu

Overview:
- Downstream stage of the 7x7 multi-channel convolution. It consumes the per-input-channel partial-sum stream and sums CHANNEL_NUM_IN partial planes per output channel.
- It adds one bias per output channel, then applies optional ReLU with saturation.
- It emits one finished output-channel plane of IMAGE_SIZE pixels per CHANNEL_NUM_OUT iteration.
- Accumulation state is held in an internal IMAGE_SIZE-deep plane buffer, written by read-modify-write.

Parameters:
- DATA_WIDTH, 32: width of partial sums, bias and output; signed two's complement fixed point.
- IMAGE_SIZE, 16: pixels per plane (IMAGE_WIDTH*IMAGE_HEIGHT of the conv output).
- CHANNEL_NUM_IN, 3: partial planes summed per output pixel; must be >= 1.
- CHANNEL_NUM_OUT, 8: output channels per frame; also the bias FIFO depth.
- RELU_EN, 1: 1 means negative results are forced to 0; 0 means pass-through.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (reset==0 resets the block on the clk edge)
- valid_in  input  1  pxl_in qualifier; one partial sum per asserted cycle, no backpressure
- pxl_in  input  DATA_WIDTH  partial sum; order is chout outer, chin middle, pixel inner
- valid_bias_in  input  1  bias_in qualifier; one push into the bias FIFO
- bias_in  input  DATA_WIDTH  bias for the next output channel, in channel order
- pxl_out  output  DATA_WIDTH  finished output pixel
- valid_out  output  1  pxl_out qualifier
- plane_done  output  1  one-cycle pulse with the last pixel of each output plane
- bias_err  output  1  sticky flag: bias FIFO was empty when a bias was needed

Behaviour:
- Reset (reset==0 at a clk edge):
  - pxl_out=0, valid_out=0, plane_done=0, bias_err=0.
  - pix_cnt, chin_cnt, chout_cnt cleared to 0.
  - Bias FIFO emptied.
  - Plane buffer contents are don't-care; they are never read before being written.
- Reset mid-plane discards all partial state. The next valid_in is treated as pixel 0, chin 0, chout 0.

Counters, advancing only on valid_in:
- pix_cnt wraps at IMAGE_SIZE-1, then increments chin_cnt.
- chin_cnt wraps at CHANNEL_NUM_IN-1, then increments chout_cnt.
- chout_cnt wraps at CHANNEL_NUM_OUT-1 back to 0, which starts a new frame.

Bias handling:
- cur_bias is popped from the FIFO on the first valid_in of each output channel (pix_cnt==0, chin_cnt==0).
- It is held for that whole output channel.
- If the FIFO is empty at that pop, cur_bias=0 and bias_err is set. bias_err stays set until reset.
- A push and a pop in the same cycle are both honoured.
- A push into a full FIFO is dropped and sets bias_err.

Per valid_in, the summand s is selected as follows:
- chin_cnt==0: s = bias (the popped value in the pop cycle, cur_bias afterwards).
- Otherwise: s = buf[pix_cnt].

Sum and ReLU:
- Sum r = sat(s + pxl_in). The add is DATA_WIDTH+1 bits wide.
- On overflow r clamps to +max = 2^(DW-1)-1 or -min = -2^(DW-1).
- If chin_cnt < CHANNEL_NUM_IN-1: buf[pix_cnt] <= r, no output.
- If chin_cnt == CHANNEL_NUM_IN-1: no buffer write. On the next cycle:
  - pxl_out = (RELU_EN && r<0) ? 0 : r
  - valid_out = 1
- plane_done = 1 on the same cycle when pix_cnt was IMAGE_SIZE-1.
- CHANNEL_NUM_IN==1: every pixel outputs bias+pxl_in directly and the buffer is unused.

Timing:
- Latency is fixed at 1 cycle from the final-channel valid_in to valid_out.
- Gapless input gives gapless output.
- Idle cycles (valid_in=0) hold all counters. valid_out returns to 0 and pxl_out holds its last value.
- The buffer read and write at the same index in the same cycle. Successive writes to one index are IMAGE_SIZE valid cycles apart, so no hazard exists. The implementation uses an asynchronous-read array, or a synchronous read with a write-forwarding path, to meet the 1-cycle latency.
- No handshake exists toward the upstream stage. Input arriving with the counters at any state is always accepted.

Test Plan:
- DW=16, IMAGE_SIZE=4, CHIN=3, CHOUT=2, RELU_EN=1; biases 10 and -5.
  - Stimulus: partials pixel p, chin c = p+c for chout 0; all 1 for chout 1.
  - Required: chout0 out 13,16,19,22; chout1 out -2 clamped to 0,0,0,0.
  - plane_done on the 4th and 8th outputs.
- RELU_EN=0, same stimulus: chout1 outputs -2,-2,-2,-2.
- Saturation: bias 32000, partials 1000,1000,1000 -> out 32767. Bias -32000, partials -1000 x3, RELU_EN=0 -> -32768.
- Bubbles and CHIN=1:
  - valid_in toggled 1/0 randomly: outputs equal the gapless run, each exactly 1 cycle after its final-channel input.
  - CHIN=1, bias 7, pxl 3 -> out 10.
- Empty bias FIFO: no bias loaded, stream chout 0 -> bias treated as 0 and bias_err=1. bias_err stays 1 through later valid biases until reset.
- Reset mid-operation:
  - Assert reset==0 after 6 valid inputs of chout 0, then reload biases and restart the stream.
  - Outputs match a clean run; no stray valid_out during or after reset; bias_err=0.
